fq_bcd_display: RTL

//  Downstream consumer of fq_measure: converts the 32-bit binary measured_freq (Hz) into

---
 rtl/fq_pkg.sv | 32 +++
 rtl/fq_seg_decode.sv | 36 +++
 rtl/fq_bcd_display.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fq_pkg.sv
// fq_pkg -- shared constants for the frequency display path.
//   BCD_DIGITS : width of the packed BCD result in digits
//   BIN_W      : width of the binary frequency input
//   SR_W       : width of the double-dabble shift register (BCD field + binary field)
//   state_e    : conversion FSM states
//   SEG_*      : active-high {g,f,e,d,c,b,a} patterns for digits, dash and blank
package fq_pkg;

  localparam int BCD_DIGITS = 10;
  localparam int BIN_W      = 32;
  localparam int SR_W       = BIN_W + 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/fq_seg_decode.sv
// fq_seg_decode -- combinational BCD to 7-segment decoder.
//   bcd_i   : one BCD digit
//   blank_i : force all segments off (leading-zero suppression)
//   dash_i  : force a '-' (over-range indication); wins over blank_i
//   seg_o   : active-high segments {g,f,e,d,c,b,a}
module fq_seg_decode
  import fq_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;  // non-BCD codes are shown blank
      endcase
    end
  end

endmodule

// File: rtl/fq_bcd_display.sv
// fq_bcd_display -- binary frequency to packed BCD (sequential double-dabble)
// and multiplexed 7-segment display driver.
//   ref_freq      : clock, rising edge
//   nReset        : asynchronous active-low reset
//   measured_freq : binary frequency in Hz (quasi-static)
//   bcd           : 10 packed BCD digits, digit 0 in [3:0]
//   bcd_valid     : one-cycle pulse when bcd updates
//   busy          : conversion in progress
//   over_range    : value needs more than DIGITS digits
//   seg           : active-high segments {g,f,e,d,c,b,a} for the selected digit
//   digit_en      : one-hot active-high digit select
module fq_bcd_display
  import fq_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  ref_freq,
  input  logic                  nReset,
  input  logic [BIN_W-1:0]      measured_freq,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  over_range,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BCD_W = 4 * BCD_DIGITS;

  // Digits at or above DIGITS cannot be displayed; any nonzero one there is over-range.
  localparam logic [BCD_DIGITS-1:0] OVER_MASK =
    ~BCD_DIGITS'((11'd1 << DIGITS) - 11'd1);

  // ---------------------------------------------------------------------------
  // Conversion FSM and datapath
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  logic [BIN_W-1:0]      last_q, last_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [SR_W-1:0]       sr_adj;
  logic [4:0]            iter_q, iter_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  bcd_valid_q, bcd_valid_d;
  logic                  busy_q, busy_d;
  logic                  over_q, over_d;
  logic [BCD_DIGITS-1:0] sr_digit_nz;

  // Add-3 correction on every BCD nibble of the shift register, ahead of the shift.
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
      logic [3:0] nib;
      assign nib = sr_q[BIN_W + 4*gi +: 4];
      assign sr_adj[BIN_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      assign sr_digit_nz[gi] = |nib;
    end
  endgenerate

  // State register
  always_ff @(posedge ref_freq or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (measured_freq != last_q) state_d = SHIFT;
      SHIFT:   if (iter_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    last_d      = last_q;
    sr_d        = sr_q;
    iter_d      = iter_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    busy_d      = busy_q;
    over_d      = over_q;
    case (state_q)
      IDLE: begin
        if (measured_freq != last_q) begin
          last_d = measured_freq;
          sr_d   = {{BCD_W{1'b0}}, measured_freq};
          iter_d = 5'd0;
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        sr_d   = {sr_adj[SR_W-2:0], 1'b0};
        iter_d = iter_q + 5'd1;
      end
      DONE: begin
        bcd_d       = sr_q[SR_W-1:BIN_W];
        bcd_valid_d = 1'b1;
        busy_d      = 1'b0;
        over_d      = |(sr_digit_nz & OVER_MASK);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ref_freq or negedge nReset) begin
    if (!nReset) begin
      last_q      <= '0;
      sr_q        <= '0;
      iter_q      <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      last_q      <= last_d;
      sr_q        <= sr_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
      over_q      <= over_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan (free-running, independent of the FSM)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          sel_nib;
  logic                sel_blank;
  logic [BCD_DIGITS:0] zero_from;  // zero_from[k]: digits k..9 of bcd are all zero

  assign zero_from[BCD_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_zero
      assign zero_from[gi] = (bcd_q[4*gi +: 4] == 4'd0) && zero_from[gi+1];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    digit_en_d = DIGITS'(1) << idx_d;
  end

  // Segments are computed for the digit that becomes active on this edge, so
  // seg and digit_en always change together.
  always_comb begin
    sel_nib   = 4'd0;
    sel_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        sel_nib   = bcd_q[4*k +: 4];
        sel_blank = (k != 0) && zero_from[k];
      end
    end
  end

  fq_seg_decode u_seg_decode (
    .bcd_i   (sel_nib),
    .blank_i (sel_blank),
    .dash_i  (over_q),
    .seg_o   (seg_d)
  );

  always_ff @(posedge ref_freq or negedge nReset) begin
    if (!nReset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      digit_en_q <= DIGITS'(1);
      seg_q      <= SEG_0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      digit_en_q <= digit_en_d;
      seg_q      <= seg_d;
    end
  end

  assign bcd        = bcd_q;
  assign bcd_valid  = bcd_valid_q;
  assign busy       = busy_q;
  assign over_range = over_q;
  assign seg        = seg_q;
  assign digit_en   = digit_en_q;

endmodule
